// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer: FSM state encoding,
// PI gain codes, frequency-word width and the phase-error magnitude helper.
package pll_seq_pkg;

  localparam int FREQ_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWEEP   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } pll_state_e;

  localparam logic [1:0] GAIN_OFF   = 2'd0;
  localparam logic [1:0] GAIN_TRACK = 2'd1;
  localparam logic [1:0] GAIN_ACQ   = 2'd2;

  // Unsigned magnitude; -128 maps to 128 so it can never pass a small threshold.
  function automatic logic [7:0] abs_err(input logic signed [7:0] e);
    logic [7:0] u;
    u = e;
    return u[7] ? (~u + 8'd1) : u;
  endfunction

endpackage

// File: rtl/pll_seq_lock_detect.sv
// Phase-error qualifier: magnitude/threshold compare plus consecutive
// in-lock and out-of-lock sample counters with a synchronous clear.
module pll_seq_lock_detect
  import pll_seq_pkg::*;
#(
  parameter int LOCK_THRESH  = 4,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic signed [7:0] phase_err_i,
  input  logic              err_valid_i,
  output logic              in_lock_o,
  output logic              out_lock_o,
  output logic              lock_hit_o,
  output logic              unlock_hit_o
);

  localparam int IN_W  = $clog2(LOCK_COUNT + 1);
  localparam int OUT_W = $clog2(UNLOCK_COUNT + 1);
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(LOCK_COUNT - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(UNLOCK_COUNT - 1);
  localparam logic [8:0]       THRESH9  = 9'(LOCK_THRESH);

  logic [7:0]       mag;
  logic [IN_W-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;

  assign mag          = abs_err(phase_err_i);
  assign in_lock_o    = err_valid_i && ({1'b0, mag} <= THRESH9);
  assign out_lock_o   = err_valid_i && !in_lock_o;
  assign lock_hit_o   = in_lock_o && (in_cnt_q == IN_LAST);
  assign unlock_hit_o = out_lock_o && (out_cnt_q == OUT_LAST);

  // Counts saturate at their last value; the FSM leaves (and clears) on a hit.
  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (clear_i) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else if (in_lock_o) begin
      out_cnt_d = '0;
      if (in_cnt_q != IN_LAST) in_cnt_d = in_cnt_q + IN_W'(1);
    end else if (out_lock_o) begin
      in_cnt_d = '0;
      if (out_cnt_q != OUT_LAST) out_cnt_d = out_cnt_q + OUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: frequency sweep, acquisition, lock tracking and fault.
// Build option PLL_SEQ_RELOCK_EN: loss of lock re-enters ACQUIRE instead of FAULT.
//
// state   | meaning
// IDLE    | waiting for start, loop off
// SWEEP   | stepping freq_word until an in-lock sample is seen
// ACQUIRE | loop on at high gain, counting consecutive in-lock samples
// LOCKED  | loop on at low gain, watching for consecutive out-of-lock samples
// FAULT   | sweep exhausted or lock lost, waiting for start
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter logic [FREQ_W-1:0] SWEEP_START  = 16'h0400,
  parameter logic [FREQ_W-1:0] SWEEP_STEP   = 16'h0010,
  parameter logic [FREQ_W-1:0] SWEEP_END    = 16'h0800,
  parameter int                LOCK_THRESH  = 4,
  parameter int                LOCK_COUNT   = 8,
  parameter int                UNLOCK_COUNT = 4,
  parameter int                ACQ_TIMEOUT  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic signed [7:0] phase_err,
  input  logic              err_valid,
  output logic [FREQ_W-1:0] freq_word,
  output logic              loop_en,
  output logic [1:0]        gain_sel,
  output logic              locked,
  output logic              busy,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int              TMR_W    = $clog2(ACQ_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACQ_TIMEOUT - 1);

  pll_state_e        state_q;
  logic [FREQ_W-1:0] freq_q;
  logic              loop_en_q;
  logic [1:0]        gain_q;
  logic              locked_q;
  logic              busy_q;
  logic              fault_q;
  logic [TMR_W-1:0]  tmr_q;

  logic            in_lock, out_lock, lock_hit, unlock_hit;
  logic            tmr_done;
  logic            det_clear;
  logic [FREQ_W:0] step_sum;
  logic            step_over;

  assign tmr_done  = (tmr_q == '0);
  assign step_sum  = {1'b0, freq_q} + {1'b0, SWEEP_STEP};
  assign step_over = step_sum > {1'b0, SWEEP_END};

  // Counters only run in ACQUIRE/LOCKED and are wiped on every transition out.
  assign det_clear = abort
                  || (state_q == ST_IDLE) || (state_q == ST_SWEEP) || (state_q == ST_FAULT)
                  || ((state_q == ST_ACQUIRE) && (lock_hit || tmr_done))
                  || ((state_q == ST_LOCKED) && unlock_hit);

  pll_seq_lock_detect #(
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) u_lock_detect (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (det_clear),
    .phase_err_i (phase_err),
    .err_valid_i (err_valid),
    .in_lock_o   (in_lock),
    .out_lock_o  (out_lock),
    .lock_hit_o  (lock_hit),
    .unlock_hit_o(unlock_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      freq_q    <= SWEEP_START;
      loop_en_q <= 1'b0;
      gain_q    <= GAIN_OFF;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      tmr_q     <= '0;
    end else if (abort) begin
      state_q   <= ST_IDLE;
      loop_en_q <= 1'b0;
      gain_q    <= GAIN_OFF;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      tmr_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SWEEP;
            freq_q  <= SWEEP_START;
            busy_q  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (in_lock) begin
            state_q   <= ST_ACQUIRE;
            loop_en_q <= 1'b1;
            gain_q    <= GAIN_ACQ;
            tmr_q     <= TMR_LOAD;
          end else if (out_lock) begin
            if (step_over) begin
              state_q <= ST_FAULT;
              busy_q  <= 1'b0;
              fault_q <= 1'b1;
            end else begin
              freq_q <= step_sum[FREQ_W-1:0];
            end
          end
        end
        ST_ACQUIRE: begin
          // Lock completion takes priority over an expiring timer.
          if (lock_hit) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
            gain_q   <= GAIN_TRACK;
          end else if (tmr_done) begin
            loop_en_q <= 1'b0;
            gain_q    <= GAIN_OFF;
            if (step_over) begin
              state_q <= ST_FAULT;
              busy_q  <= 1'b0;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_SWEEP;
              freq_q  <= step_sum[FREQ_W-1:0];
            end
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_LOCKED: begin
          if (unlock_hit) begin
            locked_q <= 1'b0;
`ifdef PLL_SEQ_RELOCK_EN
            state_q <= ST_ACQUIRE;
            gain_q  <= GAIN_ACQ;
            tmr_q   <= TMR_LOAD;
`else
            state_q   <= ST_FAULT;
            loop_en_q <= 1'b0;
            gain_q    <= GAIN_OFF;
            busy_q    <= 1'b0;
            fault_q   <= 1'b1;
`endif
          end
        end
        ST_FAULT: begin
          if (start) begin
            state_q <= ST_SWEEP;
            freq_q  <= SWEEP_START;
            busy_q  <= 1'b1;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          loop_en_q <= 1'b0;
          gain_q    <= GAIN_OFF;
          locked_q  <= 1'b0;
          busy_q    <= 1'b0;
          fault_q   <= 1'b0;
        end
      endcase
    end
  end

  assign freq_word = freq_q;
  assign loop_en   = loop_en_q;
  assign gain_sel  = gain_q;
  assign locked    = locked_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter SWEEP_START, default 16'h0400, first frequency word of the sweep.
REQ-002 Parameter SWEEP_STEP, default 16'h0010, frequency word increment per sweep step.
REQ-003 Parameter SWEEP_END, default 16'h0800, highest legal frequency word.
REQ-004 Parameter LOCK_THRESH, default 4, maximum |phase_err| counted as in-lock.
REQ-005 Parameter LOCK_COUNT, default 8, consecutive in-lock samples needed to declare lock.
REQ-006 Parameter UNLOCK_COUNT, default 4, consecutive out-of-lock samples needed to declare loss of lock.
REQ-007 Parameter ACQ_TIMEOUT, default 256, clk cycles allowed in ACQUIRE.
REQ-008 Clocking SHALL be: reset reset, asynchronous, active-high; clock clk.
REQ-009 Port clk, input, 1, system clock.
REQ-010 Port reset, input, 1, asynchronous active-high reset.
REQ-011 Port start, input, 1, single-cycle request to begin acquisition.
REQ-012 Port abort, input, 1, single-cycle request to return to IDLE.
REQ-013 Port phase_err, input, signed 8, phase-detector error sample.
REQ-014 Port err_valid, input, 1, phase_err qualifier.
REQ-015 Port freq_word, output, 16, frequency word to the NCO.
REQ-016 Port loop_en, output, 1, enables the PI loop.
REQ-017 Port gain_sel, output, 2, PI gain code: 0 off, 1 track (low), 2 acquire (high).
REQ-018 Ports locked, busy, fault, output, 1 each: lock status, not-IDLE/FAULT, sweep exhausted.
REQ-019 Port state, output, 3, current FSM state encoding.

Function
REQ-020 The FSM SHALL have states IDLE, SWEEP, ACQUIRE, LOCKED, FAULT; all outputs SHALL be registered.
REQ-021 |phase_err| SHALL be computed unsigned 8-bit, with -128 giving 128; a sample is in-lock when err_valid=1 and |phase_err| <= LOCK_THRESH.
REQ-022 IDLE: start -> SWEEP next cycle with freq_word=SWEEP_START, loop_en=0, gain_sel=0.
REQ-023 SWEEP: in-lock sample -> ACQUIRE; out-of-lock sample -> freq_word += SWEEP_STEP, unless the sum exceeds SWEEP_END (computed 17-bit, no wrap), in which case -> FAULT with freq_word held.
REQ-024 ACQUIRE: loop_en=1, gain_sel=2; consecutive in-lock count reaching LOCK_COUNT -> LOCKED; any out-of-lock sample clears the count; cycles without err_valid leave the count unchanged.
REQ-025 ACQUIRE timeout: after ACQ_TIMEOUT cycles in the state, -> SWEEP with loop_en=0, advancing freq_word per the REQ-023 rule (FAULT if past SWEEP_END); a lock-count completion in the same cycle wins over timeout.
REQ-026 LOCKED: locked=1, loop_en=1, gain_sel=1; UNLOCK_COUNT consecutive out-of-lock samples -> loss-of-lock action (REQ-033); an in-lock sample clears the count.
REQ-027 FAULT: fault=1, loop_en=0, gain_sel=0; start -> SWEEP from SWEEP_START with fault cleared.
REQ-028 abort in any state -> IDLE next cycle with loop_en=0, locked=0, fault=0; abort wins over a simultaneous start.
REQ-029 start outside IDLE and FAULT SHALL be ignored.
REQ-030 busy SHALL be 1 in SWEEP, ACQUIRE and LOCKED only.
REQ-031 All counters SHALL clear on every state entry.

Reset
REQ-032 On reset: state=IDLE, freq_word=SWEEP_START, loop_en=0, gain_sel=0, and locked, busy and fault all 0; all counters cleared.

Configuration
REQ-033 Macro PLL_SEQ_RELOCK_EN: defined, loss of lock -> ACQUIRE with freq_word held; undefined, loss of lock -> FAULT.

Structure
REQ-034 Package pll_seq_pkg SHALL hold the state enum, the gain_sel code constants and the frequency-word width.
REQ-035 Sub-module pll_seq_lock_detect SHALL implement the absolute value, the threshold compare and the consecutive in/out counters, with a clear input.

Verification
REQ-036 reset, then start, with phase_err=0 valid every cycle -> SWEEP, then ACQUIRE, then locked=1 after 8 valid samples, gain_sel=1, freq_word=16'h0400.
REQ-037 phase_err=50 valid every cycle -> freq_word steps 16'h0400..16'h0800 (64 steps), then fault=1 with freq_word=16'h0800.
REQ-038 ACQUIRE with alternating phase_err 0/50 -> SWEEP after 256 cycles, freq_word=16'h0410.
REQ-039 LOCKED, then 4 samples of phase_err=-128 -> ACQUIRE with PLL_SEQ_RELOCK_EN defined, FAULT without it.
REQ-040 start and abort together in LOCKED -> IDLE, locked=0; reset asserted mid-SWEEP -> all outputs at reset values immediately.
